// File: rtl/holy_plic_prio.sv
// rtl/holy_plic_prio.sv - Prioritised single-context PLIC with edge/level gateways and AXI-lite registers
module holy_plic_prio #(
    parameter int          NUM_IRQS    = 8,
    parameter int          PRIO_BITS   = 3,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_IRQS-1:0] irq_in,
    output logic                ext_irq_o,
    input  logic [31:0]         s_axil_awaddr,
    input  logic                s_axil_awvalid,
    output logic                s_axil_awready,
    input  logic [31:0]         s_axil_wdata,
    input  logic [3:0]          s_axil_wstrb,
    input  logic                s_axil_wvalid,
    output logic                s_axil_wready,
    output logic [1:0]          s_axil_bresp,
    output logic                s_axil_bvalid,
    input  logic                s_axil_bready,
    input  logic [31:0]         s_axil_araddr,
    input  logic                s_axil_arvalid,
    output logic                s_axil_arready,
    output logic [31:0]         s_axil_rdata,
    output logic [1:0]          s_axil_rresp,
    output logic                s_axil_rvalid,
    input  logic                s_axil_rready
);
    localparam logic [11:0] OFF_PENDING = 12'h100;
    localparam logic [11:0] OFF_ENABLE  = 12'h104;
    localparam logic [11:0] OFF_MODE    = 12'h108;
    localparam logic [11:0] OFF_THRESH  = 12'h10C;
    localparam logic [11:0] OFF_CLAIM   = 12'h110;
    localparam logic [11:0] OFF_INSERV  = 12'h114;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    // Bitmaps are indexed by source ID; bit 0 (reserved ID) is held at 0.
    logic [NUM_IRQS:0]    pending_q, pending_d, enable_q, enable_d, mode_q, mode_d;
    logic [NUM_IRQS:0]    in_service_q, in_service_d, edge_latch_q, edge_latch_d;
    logic [PRIO_BITS-1:0] prio_q [NUM_IRQS+1];
    logic [PRIO_BITS-1:0] prio_d [NUM_IRQS+1];
    logic [PRIO_BITS-1:0] threshold_q, threshold_d;
    logic                 ext_irq_q, ext_irq_d;
    logic [NUM_IRQS-1:0]  irq_sync, irq_prev_q, irq_prev_d;

    logic        aw_full_q, aw_full_d, w_full_q, w_full_d, bvalid_q, bvalid_d;
    logic [1:0]  bresp_q, bresp_d, rresp_q, rresp_d;
    logic [31:0] aw_addr_q, aw_addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        rvalid_q, rvalid_d;

    logic [NUM_IRQS:0]    eligible, rise;
    logic [PRIO_BITS-1:0] best_prio;
    logic [4:0]           best_id;
    logic [11:0]          aw_off;
    logic [31:0]          rd_val, wr_cur, wr_new, wmask;
    logic                 rd_ok, wr_ok, wr_commit, unused_ok;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign irq_sync = irq_in;
        end else begin : g_sync
            logic [NUM_IRQS-1:0] sync_q [SYNC_STAGES];
            logic [NUM_IRQS-1:0] sync_d [SYNC_STAGES];
            always_comb begin
                sync_d[0] = irq_in;
                for (int s = 1; s < SYNC_STAGES; s++) sync_d[s] = sync_q[s-1];
            end
            always_ff @(posedge clk) begin
                for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= rst ? '0 : sync_d[s];
            end
            assign irq_sync = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    function automatic logic addr_mapped(input logic [31:0] addr);
        if (addr[31:12] != BASE_ADDR[31:12] || addr[1:0] != 2'b00) return 1'b0;
        if (addr[11:8] == 4'h0) return int'(addr[7:2]) <= NUM_IRQS;
        return addr[11:0] inside {OFF_PENDING, OFF_ENABLE, OFF_MODE, OFF_THRESH, OFF_CLAIM, OFF_INSERV};
    endfunction

    function automatic logic [31:0] reg_value(input logic [11:0] off);
        logic [31:0] v;
        v = '0;
        if (off[11:8] == 4'h0) begin
            for (int i = 1; i <= NUM_IRQS; i++)
                if (int'(off[7:2]) == i) v[PRIO_BITS-1:0] = prio_q[i];
        end else begin
            case (off)
                OFF_PENDING: v[NUM_IRQS:0]    = pending_q;
                OFF_ENABLE:  v[NUM_IRQS:0]    = enable_q;
                OFF_MODE:    v[NUM_IRQS:0]    = mode_q;
                OFF_THRESH:  v[PRIO_BITS-1:0] = threshold_q;
                OFF_CLAIM:   v[4:0]           = best_id;
                OFF_INSERV:  v[NUM_IRQS:0]    = in_service_q;
                default:     v = '0;
            endcase
        end
        return v;
    endfunction

    // Highest priority wins; scanning downward with >= lets the lowest ID take ties.
    always_comb begin
        eligible  = '0;
        best_id   = '0;
        best_prio = '0;
        for (int i = NUM_IRQS; i >= 1; i--) begin
            eligible[i] = pending_q[i] & enable_q[i] & (prio_q[i] > threshold_q);
            if (eligible[i] && prio_q[i] >= best_prio) begin
                best_prio = prio_q[i];
                best_id   = 5'(i);
            end
        end
    end

    always_comb begin
        aw_off    = aw_addr_q[11:0];
        rd_ok     = addr_mapped(s_axil_araddr);
        rd_val    = reg_value(s_axil_araddr[11:0]);
        wr_ok     = addr_mapped(aw_addr_q) && aw_off != OFF_PENDING && aw_off != OFF_INSERV;
        wr_cur    = reg_value(aw_off);
        wmask     = {{8{wstrb_q[3]}}, {8{wstrb_q[2]}}, {8{wstrb_q[1]}}, {8{wstrb_q[0]}}};
        wr_new    = (wr_cur & ~wmask) | (wdata_q & wmask);
        wr_commit = aw_full_q && w_full_q && !bvalid_q;
        rise      = {irq_sync & ~irq_prev_q, 1'b0};
    end

    assign unused_ok = ^wr_new;

    always_comb begin
        pending_d    = pending_q;
        enable_d     = enable_q;
        mode_d       = mode_q;
        in_service_d = in_service_q;
        edge_latch_d = edge_latch_q;
        prio_d       = prio_q;
        threshold_d  = threshold_q;
        irq_prev_d   = irq_sync;
        ext_irq_d    = |eligible;
        aw_full_d    = aw_full_q;
        w_full_d     = w_full_q;
        aw_addr_d    = aw_addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        bvalid_d     = bvalid_q;
        bresp_d      = bresp_q;
        rvalid_d     = rvalid_q;
        rdata_d      = rdata_q;
        rresp_d      = rresp_q;

        for (int i = 1; i <= NUM_IRQS; i++) begin
            if (mode_q[i]) begin
                if (rise[i]) begin
                    if (!pending_q[i] && !in_service_q[i]) pending_d[i] = 1'b1;
                    else edge_latch_d[i] = 1'b1;
                end
            end else if (irq_sync[i-1] && !pending_q[i] && !in_service_q[i]) begin
                pending_d[i] = 1'b1;
            end
        end

        if (s_axil_awvalid && !aw_full_q) begin
            aw_full_d = 1'b1;
            aw_addr_d = s_axil_awaddr;
        end
        if (s_axil_wvalid && !w_full_q) begin
            w_full_d = 1'b1;
            wdata_d  = s_axil_wdata;
            wstrb_d  = s_axil_wstrb;
        end

        if (wr_commit) begin
            bvalid_d = 1'b1;
            bresp_d  = wr_ok ? RESP_OKAY : RESP_SLVERR;
            if (wr_ok) begin
                if (aw_off[11:8] == 4'h0) begin
                    for (int i = 1; i <= NUM_IRQS; i++)
                        if (int'(aw_off[7:2]) == i) prio_d[i] = wr_new[PRIO_BITS-1:0];
                end else begin
                    case (aw_off)
                        OFF_ENABLE: enable_d    = {wr_new[NUM_IRQS:1], 1'b0};
                        OFF_MODE:   mode_d      = {wr_new[NUM_IRQS:1], 1'b0};
                        OFF_THRESH: threshold_d = wr_new[PRIO_BITS-1:0];
                        OFF_CLAIM: begin
                            // A latched edge becomes pending as soon as the source leaves service.
                            for (int i = 1; i <= NUM_IRQS; i++) begin
                                if (wstrb_q[0] && wdata_q[4:0] == 5'(i) && in_service_q[i]) begin
                                    in_service_d[i] = 1'b0;
                                    if (edge_latch_d[i]) begin
                                        pending_d[i]    = 1'b1;
                                        edge_latch_d[i] = 1'b0;
                                    end
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
        if (bvalid_q && s_axil_bready) begin
            bvalid_d  = 1'b0;
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
        end

        if (s_axil_arvalid && !rvalid_q) begin
            rvalid_d = 1'b1;
            rresp_d  = rd_ok ? RESP_OKAY : RESP_SLVERR;
            rdata_d  = rd_ok ? rd_val : '0;
            // Claim side effect lands once, on the AR handshake, after the gateway update.
            if (rd_ok && s_axil_araddr[11:0] == OFF_CLAIM) begin
                for (int i = 1; i <= NUM_IRQS; i++) begin
                    if (best_id == 5'(i)) begin
                        pending_d[i]    = 1'b0;
                        in_service_d[i] = 1'b1;
                    end
                end
            end
        end else if (rvalid_q && s_axil_rready) begin
            rvalid_d = 1'b0;
        end

        edge_latch_d = edge_latch_d & mode_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q    <= '0;
            enable_q     <= '0;
            mode_q       <= '0;
            in_service_q <= '0;
            edge_latch_q <= '0;
            for (int i = 0; i <= NUM_IRQS; i++) prio_q[i] <= '0;
            threshold_q  <= '0;
            irq_prev_q   <= '0;
            ext_irq_q    <= 1'b0;
            aw_full_q    <= 1'b0;
            w_full_q     <= 1'b0;
            aw_addr_q    <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            bvalid_q     <= 1'b0;
            bresp_q      <= '0;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
            rresp_q      <= '0;
        end else begin
            pending_q    <= pending_d;
            enable_q     <= enable_d;
            mode_q       <= mode_d;
            in_service_q <= in_service_d;
            edge_latch_q <= edge_latch_d;
            prio_q       <= prio_d;
            threshold_q  <= threshold_d;
            irq_prev_q   <= irq_prev_d;
            ext_irq_q    <= ext_irq_d;
            aw_full_q    <= aw_full_d;
            w_full_q     <= w_full_d;
            aw_addr_q    <= aw_addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            bvalid_q     <= bvalid_d;
            bresp_q      <= bresp_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
            rresp_q      <= rresp_d;
        end
    end

    assign ext_irq_o      = ext_irq_q;
    assign s_axil_awready = !aw_full_q;
    assign s_axil_wready  = !w_full_q;
    assign s_axil_bvalid  = bvalid_q;
    assign s_axil_bresp   = bresp_q;
    assign s_axil_arready = !rvalid_q;
    assign s_axil_rvalid  = rvalid_q;
    assign s_axil_rdata   = rdata_q;
    assign s_axil_rresp   = rresp_q;
endmodule
